// File: rtl/serial_adder_nbit_if.sv
// Handshake and data bundle for serial_adder_nbit: operand request side and result side.
interface serial_adder_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full_adder_1_bit cell, operands shifted LSB-first,
// carry kept in a flop, parallel result with carry-out and signed overflow.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end
endmodule

module serial_adder_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_nbit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             cmsb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_cout;
  logic             last;

  full_adder_1_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // sum_sr holds only the WIDTH-1 settled bits; the current bit completes the word
  always_comb begin
    sum_w = {fa_s, sum_sr};
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = SHIFT;
      SHIFT:   if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == SHIFT);
    bus.out_valid = (state == DONE);
    bus.sum       = sum_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          sum_sr  <= sum_w[WIDTH-1:1];
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          // carry into the MSB, needed for signed overflow on the final bit
          if (cnt == CW'(WIDTH - 2)) cmsb_q <= fa_cout;
          if (last) begin
            sum_q  <= sum_w;
            cout_q <= fa_cout;
            ovf_q  <= cmsb_q ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
Bit-serial N-bit adder built around the team's full_adder_1_bit cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. Operands are shifted LSB-first through a single full_adder_1_bit instance, with the carry held in a flip-flop between cycles. The result is presented as a parallel word with carry-out and signed-overflow flags through a valid/ready output handshake. The block is the sequential driver directly upstream of the full_adder_1_bit cell.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, captured on accept
b  input  WIDTH  operand B, captured on accept
cin  input  1  carry-in, captured on accept
out_valid  output  1  sum, cout, ovf are valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  unsigned carry-out of bit WIDTH-1
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
busy  output  1  high in SHIFT state

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. No asynchronous reset path.
- States: IDLE, SHIFT, DONE. Register outputs only; no combinational path from in_valid/out_ready to any output except through state.
- Reset (rst=1 at an edge): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0, busy=0; internal shift registers, carry flop and bit counter all cleared. in_ready=1 from the first cycle after reset. rst overrides every other input, including mid-SHIFT and in DONE; any partial result is discarded.
- IDLE: in_ready=1.
  - in_valid=1 at an edge (accept): load a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0, go to SHIFT.
  - in_valid=0: stay in IDLE.
  - sum/cout/ovf keep the last result; they are not cleared on accept.
- SHIFT: busy=1, in_ready=0; in_valid is ignored.
  - Each cycle, the full adder takes a_sr[0], b_sr[0], carry_q.
  - At the edge: shift the sum bit into the MSB of sum_sr; shift a_sr and b_sr right by 1; carry_q<=adder Cout; cnt<=cnt+1.
  - When cnt=WIDTH-2 at the edge, capture cmsb_q<=adder Cout. This is the carry into the MSB.
  - When cnt=WIDTH-1 at the edge:
    - sum<=completed sum_sr word (including the current bit);
    - cout<=adder Cout;
    - ovf<=cmsb_q XOR adder Cout;
    - go to DONE.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE: out_valid=1, in_ready=0.
  - Hold sum/cout/ovf stable while out_ready=0, with no limit on stall length.
  - out_ready=1 at an edge: go to IDLE. out_valid drops the next cycle.
  - in_valid asserted during DONE is not accepted. Acceptance resumes in IDLE, so there is a one-cycle bubble.
- Counter width is $clog2(WIDTH). The counter saturates at no value because it is only used in SHIFT.
- Simultaneous events: rst with in_valid means reset wins and nothing is accepted. rst with out_ready in DONE means reset wins, and outputs are cleared to 0.
- Exact result: {cout,sum} = a + b + cin for all inputs. ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid high exactly 8 edges after accept; sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0 (back-to-back, with one IDLE bubble).
- a=0x80, b=0x80, cin=0, out_ready held 0 for 5 cycles in DONE -> out_valid stays 1; sum=0x00, cout=1, ovf=1 stable; in_ready=0 throughout; in_valid pulses ignored; IDLE entered on the edge after out_ready=1.
- in_valid asserted on every cycle of SHIFT with a=0x11, b=0x22 -> no re-accept, busy=1 for 8 cycles, result matches the first operands only.
- rst=1 at cnt=3 of a 0x7F+0x01 operation -> next cycle state=IDLE; sum=0, cout=0, ovf=0, out_valid=0, in_ready=1. A fresh 0x01+0x02 then yields sum=0x03.
- Random regression over 10k operand/cin triples, for WIDTH=8 and WIDTH=2, with random out_ready stalls -> {cout,sum}=a+b+cin and the ovf formula hold on every transaction.
